// File: rtl/mem_bank_mp.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bank_mp
//  Purpose  : Multi-port word memory with byte-lane writes, per-word tag and
//             shared bit, fixed-latency pipelined reads and a saturating
//             count of rejected writes.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             wen/waddr/wsz/wdata/wshare - NWR write ports (byte address)
//             werr               - per-port pulse, write rejected last cycle
//             ren/raddr          - NRD read ports (word address)
//             rvalid/rdata/raddr_out - read results, RDLAT cycles after ren
//             errcnt             - saturating rejected-write count
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bank_mp #(
    parameter int NWR   = 4,
    parameter int NRD   = 2,
    parameter int AW    = 16,
    parameter int TAGW  = 2,
    parameter int RDLAT = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NWR-1:0]                    wen,
    input  logic [NWR-1:0][AW-1:0]            waddr,
    input  logic [NWR-1:0][1:0]               wsz,
    input  logic [NWR-1:0][64+TAGW-1:0]       wdata,
    input  logic [NWR-1:0]                    wshare,
    output logic [NWR-1:0]                    werr,
    input  logic [NRD-1:0]                    ren,
    input  logic [NRD-1:0][AW-4:0]            raddr,
    output logic [NRD-1:0]                    rvalid,
    output logic [NRD-1:0][65+TAGW-1:0]       rdata,
    output logic [NRD-1:0][AW-4:0]            raddr_out,
    output logic [15:0]                       errcnt
);
    localparam int WW    = 65 + TAGW;   // {shared, tag, data}
    localparam int DEPTH = 1 << (AW - 3);

    logic [WW-1:0] mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Write decode: acceptance, byte-enable mask and lane-aligned data
    // ------------------------------------------------------------------
    logic [NWR-1:0][2:0]    w_off;
    logic [NWR-1:0][3:0]    w_end;
    logic [NWR-1:0]         w_ok;
    logic [NWR-1:0][7:0]    w_mask;
    logic [NWR-1:0][7:0]    w_be;
    logic [NWR-1:0][63:0]   w_wd;
    logic [NWR-1:0][AW-4:0] w_word;

    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            w_off[p]  = waddr[p][2:0];
            w_word[p] = waddr[p][AW-1:3];
            // 4-bit sum cannot overflow (max 7 + 8)
            w_end[p]  = {1'b0, w_off[p]} + (4'd1 << wsz[p]);
            w_ok[p]   = wen[p] && (w_end[p] <= 4'd8);
            case (wsz[p])
                2'd0:    w_mask[p] = 8'h01;
                2'd1:    w_mask[p] = 8'h03;
                2'd2:    w_mask[p] = 8'h0F;
                default: w_mask[p] = 8'hFF;
            endcase
            w_be[p] = w_mask[p] << w_off[p];
            w_wd[p] = wdata[p][63:0] << {w_off[p], 3'b000};
        end
    end

    // Storage is never reset. Ports are applied in ascending order so the
    // highest-indexed port's non-blocking update lands last and wins for
    // each byte lane, the tag and the shared bit independently.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NWR; p++) begin
            if (w_ok[p]) begin
                for (int b = 0; b < 8; b++) begin
                    if (w_be[p][b]) begin
                        mem_q[w_word[p]][8*b +: 8] <= w_wd[p][8*b +: 8];
                    end
                end
                if (wsz[p] == 2'd3) begin
                    mem_q[w_word[p]][64 +: TAGW] <= wdata[p][64 +: TAGW];
                end
                mem_q[w_word[p]][WW-1] <= wshare[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Error pulse and saturating counter
    // ------------------------------------------------------------------
    logic [NWR-1:0] werr_q;
    logic [NWR-1:0] werr_d;
    logic [15:0]    errcnt_q;
    logic [15:0]    errcnt_d;
    logic [16:0]    w_errsum;

    always_comb begin
        werr_d   = wen & ~w_ok;
        w_errsum = {1'b0, errcnt_q};
        for (int p = 0; p < NWR; p++) begin
            w_errsum = w_errsum + 17'(werr_q[p]);
        end
        errcnt_d = w_errsum[16] ? 16'hFFFF : w_errsum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            werr_q   <= '0;
            errcnt_q <= '0;
        end else begin
            werr_q   <= werr_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign werr   = werr_q;
    assign errcnt = errcnt_q;

    // ------------------------------------------------------------------
    // Read pipeline. Stage 1 holds the captured address; the array is read
    // during stage 1, after the capturing edge has committed that cycle's
    // writes, which gives write-first ordering. Address/data registers only
    // load behind a valid so the outputs hold between results.
    // ------------------------------------------------------------------
    logic [RDLAT:1][NRD-1:0]         rv_q;
    logic [RDLAT:1][NRD-1:0][AW-4:0] ra_q;
    logic [NRD-1:0][WW-1:0]          w_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q <= '0;
            ra_q <= '0;
        end else begin
            rv_q[1] <= ren;
            for (int p = 0; p < NRD; p++) begin
                if (ren[p]) ra_q[1][p] <= raddr[p];
            end
            for (int k = 2; k <= RDLAT; k++) begin
                rv_q[k] <= rv_q[k-1];
                for (int p = 0; p < NRD; p++) begin
                    if (rv_q[k-1][p]) ra_q[k][p] <= ra_q[k-1][p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            w_rd[p] = mem_q[ra_q[1][p]];
        end
    end

    generate
        if (RDLAT == 1) begin : g_lat1
            logic [NRD-1:0][WW-1:0] hold_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_q <= '0;
                end else begin
                    for (int p = 0; p < NRD; p++) begin
                        if (rv_q[1][p]) hold_q[p] <= w_rd[p];
                    end
                end
            end

            always_comb begin
                for (int p = 0; p < NRD; p++) begin
                    rdata[p] = rv_q[1][p] ? w_rd[p] : hold_q[p];
                end
            end
        end else begin : g_latn
            logic [RDLAT:2][NRD-1:0][WW-1:0] rd_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else begin
                    for (int p = 0; p < NRD; p++) begin
                        if (rv_q[1][p]) rd_q[2][p] <= w_rd[p];
                        for (int k = 3; k <= RDLAT; k++) begin
                            if (rv_q[k-1][p]) rd_q[k][p] <= rd_q[k-1][p];
                        end
                    end
                end
            end

            assign rdata = rd_q[RDLAT];
        end
    endgenerate

    assign rvalid    = rv_q[RDLAT];
    assign raddr_out = ra_q[RDLAT];

endmodule
`default_nettype wire

// File: doc/mem_bank_mp.md
MEM_BANK_MP -- requirements
Module: mem_bank_mp

Interface
REQ-001 Parameter NWR, default 4, number of write ports.
REQ-002 Parameter NRD, default 2, number of read ports.
REQ-003 Parameter AW, default 16, byte-address width; DEPTH = 2^(AW-3) words.
REQ-004 Parameter TAGW, default 2, tag bits stored above the 64 data bits.
REQ-005 Parameter RDLAT, default 2, read latency in cycles, legal range 1..4.
REQ-006 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Port rst  input  1  asynchronous, active-high reset.
REQ-008 Port wen  input  NWR  per-port write enable.
REQ-009 Port waddr  input  NWR x AW  byte address.
REQ-010 Port wsz  input  NWR x 2  size code; bytes = 1<<wsz (1, 2, 4 or 8).
REQ-011 Port wdata  input  NWR x (64+TAGW)  data; byte k of the access is wdata[8k+:8]; tag is wdata[64+:TAGW].
REQ-012 Port wshare  input  NWR  value written to the word's shared bit.
REQ-013 Port werr  output  NWR  pulse; the write was rejected.
REQ-014 Port ren  input  NRD  per-port read enable.
REQ-015 Port raddr  input  NRD x (AW-3)  word address.
REQ-016 Port rvalid  output  NRD  read data valid.
REQ-017 Port rdata  output  NRD x (65+TAGW)  layout {shared, tag, data[63:0]}.
REQ-018 Port raddr_out  output  NRD x (AW-3)  address echoed alongside rdata.
REQ-019 Port errcnt  output  16  saturating count of rejected writes.

Function
REQ-020 Storage SHALL be DEPTH words of 65+TAGW bits; each word holds 64 data bits, TAGW tag bits and 1 shared bit.
REQ-021 Write acceptance: a write is accepted iff wen=1 and waddr[2:0]+(1<<wsz) <= 8.
REQ-022 Otherwise, with wen=1, the write SHALL leave storage untouched and pulse werr for that port the next cycle.
REQ-023 Byte lanes: an accepted write SHALL update bytes waddr[2:0] .. waddr[2:0]+(1<<wsz)-1 of word waddr[AW-1:3]; lane waddr[2:0]+k takes wdata byte k.
REQ-024 Tag: the tag field SHALL be written only when wsz=3 (which implies waddr[2:0]=0 for an accepted write); otherwise the tag is unchanged.
REQ-025 Shared bit: every accepted write SHALL set the word's shared bit to wshare.
REQ-026 Same-cycle collisions: when several accepted writes hit the same word and byte lane, the highest port index wins, per byte, per tag and per shared bit.
REQ-027 Read timing: a read issued at cycle T (ren=1) SHALL present rdata, raddr_out and rvalid=1 at cycle T+RDLAT for exactly one cycle.
REQ-028 Read pipeline: reads SHALL be fully pipelined, accepting one read per port per cycle with no stalls.
REQ-029 Read/write ordering: a read sees all writes accepted in cycles up to and including T (write-first); it does not see writes from cycle T+1 onward.
REQ-030 rvalid=0 cycles: rdata SHALL hold its last value.
REQ-031 errcnt SHALL increment by the number of werr bits set in a cycle, saturating at 16'hFFFF.
REQ-032 Out-of-range addresses cannot occur; address width fully covers DEPTH.

Reset
REQ-033 While rst=1: rvalid, werr, rdata, raddr_out and errcnt SHALL be 0, and in-flight reads SHALL be discarded.
REQ-034 Memory contents SHALL NOT be cleared by reset and are undefined until written.
REQ-035 Reads issued in the first cycle after rst deasserts SHALL complete normally.

Verification
REQ-036 Full write then read: port0 writes waddr=0x0010, wsz=3, wdata tag=2'b11, data=64'h0123456789ABCDEF, wshare=1; read word 2 -> after RDLAT, rdata={1,2'b11,64'h0123456789ABCDEF}.
REQ-037 Byte merge: full write to word 4 with data 0, then port1 writes waddr=0x0023, wsz=1, data 16'hBEEF -> word 4 data = 64'h000000BEEF000000, tag unchanged.
REQ-038 Collision: port0 and port3 in the same cycle write byte 0 of word 7 with 8'h11 and 8'h33 -> reads return 8'h33.
REQ-039 Misaligned: waddr=0x0006, wsz=2 -> werr pulses the next cycle, errcnt increments by 1, word contents unchanged; 4 simultaneous bad writes -> errcnt += 4; errcnt preloaded to 0xFFFE with 3 errors -> 0xFFFF.
REQ-040 Write-first and pipelining: ren on word 9 in the same cycle as a write to word 9 -> returns the new data; back-to-back reads on 5 consecutive cycles -> 5 consecutive rvalid pulses in order.
REQ-041 Reset mid-flight: assert rst one cycle after ren -> no rvalid appears; all outputs 0 during reset; data previously written is still readable after reset.
